// File: rtl/if_id_pipe.sv
// -----------------------------------------------------------------------------
// if_id_pipe
//   IF->ID pipeline register carrying the instruction word and its fetch
//   address between the fetch unit and the decoder. Provides a valid/ready
//   handshake on both sides, back-pressure from the decoder, and a flush that
//   discards every held beat and replaces the output word with NOP_INST.
//
//   Build option: define IF_ID_SKID_EN to add a one-entry skid register behind
//   the main stage. in_ready_o then comes straight from a flop, so there is no
//   combinational path from out_ready_i to in_ready_o. Without the macro,
//   in_ready_o = !out_valid_o | out_ready_i.
//
// Ports
//   clk          in   1       clock, rising edge
//   rst_n        in   1       asynchronous active-low reset
//   inst_i       in   INST_W  fetched instruction
//   inst_addr_i  in   ADDR_W  address of inst_i
//   in_valid_i   in   1       upstream beat valid
//   in_ready_o   out  1       stage can accept a beat
//   flush_i      in   1       discard all held and incoming beats
//   inst_o       out  INST_W  instruction to decode (NOP_INST when not valid)
//   inst_addr_o  out  ADDR_W  address of inst_o
//   out_valid_o  out  1       inst_o / inst_addr_o valid
//   out_ready_i  in   1       decoder accepts; 0 = stall
// -----------------------------------------------------------------------------
module if_id_pipe #(
    parameter int                 INST_W   = 32,
    parameter int                 ADDR_W   = 32,
    parameter logic [INST_W-1:0]  NOP_INST = 32'h0000_0013,
    parameter logic [ADDR_W-1:0]  RST_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [INST_W-1:0] inst_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              flush_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
);

    // Main stage. r_inst is forced to NOP_INST whenever r_valid drops, so the
    // output word needs no mux.
    logic              r_valid;
    logic [INST_W-1:0] r_inst;
    logic [ADDR_W-1:0] r_addr;

    logic              w_in_xfer;
    logic              w_out_xfer;

    assign w_in_xfer  = in_valid_i & in_ready_o;
    assign w_out_xfer = r_valid & out_ready_i;

    assign inst_o      = r_inst;
    assign inst_addr_o = r_addr;
    assign out_valid_o = r_valid;

`ifdef IF_ID_SKID_EN
    // Skid entry only ever fills while the main stage is full, so
    // "skid full" always implies "main full".
    logic              r_skid_valid;
    logic [INST_W-1:0] r_skid_inst;
    logic [ADDR_W-1:0] r_skid_addr;

    assign in_ready_o = !r_skid_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_inst       <= NOP_INST;
            r_addr       <= RST_ADDR;
            r_skid_valid <= 1'b0;
            r_skid_inst  <= NOP_INST;
            r_skid_addr  <= RST_ADDR;
        end else if (flush_i) begin
            // Any beat accepted this cycle is dropped along with held beats.
            r_valid      <= 1'b0;
            r_inst       <= NOP_INST;
            r_skid_valid <= 1'b0;
        end else if (!r_valid) begin
            if (w_in_xfer) begin
                r_valid <= 1'b1;
                r_inst  <= inst_i;
                r_addr  <= inst_addr_i;
            end
        end else if (w_out_xfer) begin
            if (r_skid_valid) begin
                // Oldest pending beat moves up; skid was refusing input.
                r_inst       <= r_skid_inst;
                r_addr       <= r_skid_addr;
                r_skid_valid <= 1'b0;
            end else if (w_in_xfer) begin
                r_inst <= inst_i;
                r_addr <= inst_addr_i;
            end else begin
                r_valid <= 1'b0;
                r_inst  <= NOP_INST;
            end
        end else if (w_in_xfer) begin
            // Main full and stalled: park the incoming beat.
            r_skid_valid <= 1'b1;
            r_skid_inst  <= inst_i;
            r_skid_addr  <= inst_addr_i;
        end
    end
`else
    assign in_ready_o = !r_valid | out_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
            r_addr  <= RST_ADDR;
        end else if (flush_i) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
        end else if (w_in_xfer) begin
            // Covers the simultaneous in/out case: new beat replaces old.
            r_valid <= 1'b1;
            r_inst  <= inst_i;
            r_addr  <= inst_addr_i;
        end else if (w_out_xfer) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_pipe.sv
// -----------------------------------------------------------------------------
// tb_if_id_pipe
//   Scoreboard bench for if_id_pipe. The stimulus process pushes every
//   accepted beat into a queue (and empties it on flush/reset); an
//   independent monitor pops and compares whenever the stage presents a beat
//   that the decoder takes. Directed tests add explicit handshake and hold
//   checks; a random phase exercises valid/ready/flush mixing.
// -----------------------------------------------------------------------------
module tb_if_id_pipe;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst_i = '0;
    logic [31:0] inst_addr_i = '0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic        flush_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [63:0] sb[$];

    if_id_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inst_i      (inst_i),
        .inst_addr_i (inst_addr_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .flush_i     (flush_i),
        .inst_o      (inst_o),
        .inst_addr_o (inst_addr_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: posedges at 5,15,...; inputs change at posedge+1, so the
    // negedge sees a stable cycle.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst_n) begin
            if (out_valid_o && out_ready_i) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL out_beat: got %h@%h expected none", inst_o, inst_addr_o);
                end else begin
                    e = sb.pop_front();
                    if ({inst_o, inst_addr_o} !== e) begin
                        errors++;
                        $display("FAIL out_beat: got %h@%h expected %h@%h",
                                 inst_o, inst_addr_o, e[63:32], e[31:0]);
                    end else begin
                        $display("ok   out_beat: %h@%h", inst_o, inst_addr_o);
                    end
                end
            end
            if (!out_valid_o) begin
                checks++;
                if (inst_o !== NOP) begin
                    errors++;
                    $display("FAIL idle_nop: got %h expected %h", inst_o, NOP);
                end
            end
        end
    end

    // One clock cycle of stimulus; called at posedge+1.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] adr,
                         input logic rdy, input logic fl);
        in_valid_i  = v;
        inst_i      = ins;
        inst_addr_i = adr;
        out_ready_i = rdy;
        flush_i     = fl;
        #6;
        if (fl) sb.delete();
        else if (v && in_ready_o) sb.push_back({ins, adr});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] stream_i[4];
        logic [31:0] a;
        stream_i[0] = 32'h0050_0093;
        stream_i[1] = 32'h0010_0113;
        stream_i[2] = 32'h0020_0193;
        stream_i[3] = 32'h0030_0113;

        // Power-on reset
        #12;
        chk("por_inst", inst_o, NOP);
        chk("por_valid", {31'b0, out_valid_o}, 32'd0);
        chk("por_ready", {31'b0, in_ready_o}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Stream: 4 beats back to back, decoder always ready
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, stream_i[k], 32'(k * 4), 1'b1, 1'b0);
            chk("stream_lat", inst_o, stream_i[k]);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("stream_end_valid", {31'b0, out_valid_o}, 32'd0);

        // Stall: A held for 3 cycles with B presented
        cycle(1'b1, 32'h0000_A0A0, 32'h10, 1'b0, 1'b0);
`ifdef IF_ID_SKID_EN
        chk("stall_ready_first", {31'b0, in_ready_o}, 32'd1);
`else
        chk("stall_ready_first", {31'b0, in_ready_o}, 32'd0);
`endif
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 32'h0000_B0B0, 32'h14, 1'b0, 1'b0);
            chk("stall_hold_inst", inst_o, 32'h0000_A0A0);
            chk("stall_hold_addr", inst_addr_o, 32'h10);
            chk("stall_ready", {31'b0, in_ready_o}, 32'd0);
        end
        for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("stall_drained", {31'b0, out_valid_o}, 32'd0);

        // Flush with B presented
        cycle(1'b1, 32'h0000_A1A1, 32'h20, 1'b1, 1'b0);
        cycle(1'b1, 32'h0000_B1B1, 32'h24, 1'b0, 1'b1);
        chk("flush_valid", {31'b0, out_valid_o}, 32'd0);
        chk("flush_inst", inst_o, NOP);
        chk("flush_addr", inst_addr_o, 32'h20);
        for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Drain: single beat then idle
        cycle(1'b1, 32'h0000_C2C2, 32'h30, 1'b1, 1'b0);
        chk("drain_valid1", {31'b0, out_valid_o}, 32'd1);
        chk("drain_inst1", inst_o, 32'h0000_C2C2);
        cycle(1'b0, 32'hDEAD_BEEF, 32'h99, 1'b1, 1'b0);
        chk("drain_valid0", {31'b0, out_valid_o}, 32'd0);
        chk("drain_nop", inst_o, NOP);
        chk("drain_addr_hold", inst_addr_o, 32'h30);

        // Async reset mid-cycle with a beat held
        cycle(1'b1, 32'h0000_D3D3, 32'h40, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("rst_inst", inst_o, NOP);
        chk("rst_addr", inst_addr_o, 32'h0);
        chk("rst_valid", {31'b0, out_valid_o}, 32'd0);
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Random valid/ready/flush
        a = 32'h1000;
        for (int k = 0; k < 10000; k++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, a, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 31) == 0));
            a = a + 32'd4;
        end

        // Drain everything, bounded
        for (int k = 0; k < 8; k++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        chk("final_valid", {31'b0, out_valid_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
